// File: rtl/decoder_pkg.sv
// Shared widths and the one-hot decode function for the 2-to-4 decoder.
package decoder_pkg;

    localparam int SEL_W   = 2;
    localparam int NUM_OUT = 4;

    // Any select that is not a clean 0/1 pattern falls to default, giving all-zero.
    function automatic logic [NUM_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] dec;
        case (sel)
            2'b00:   dec = 4'b0001;
            2'b01:   dec = 4'b0010;
            2'b10:   dec = 4'b0100;
            2'b11:   dec = 4'b1000;
            default: dec = 4'b0000;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/decoder_2to4_core.sv
// Purely combinational select-to-one-hot decode.
module decoder_2to4_core
    import decoder_pkg::*;
(
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] dec
);

    always_comb begin
        dec = onehot4(sel);
    end

endmodule

// File: rtl/decoder_2to4.sv
// 2-to-4 decoder: zero-latency one-hot outputs plus a registered copy for clocked consumers.
module decoder_2to4
    import decoder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               a0,
    input  logic               a1,
    output logic               d0,
    output logic               d1,
    output logic               d2,
    output logic               d3,
    output logic [NUM_OUT-1:0] q
);

    logic [SEL_W-1:0]   sel;
    logic [NUM_OUT-1:0] dec;

    assign sel = {a1, a0};

    decoder_2to4_core u_core (
        .sel (sel),
        .dec (dec)
    );

    assign d0 = dec[0];
    assign d1 = dec[1];
    assign d2 = dec[2];
    assign d3 = dec[3];

    // Reset only clears the registered copy; the combinational outputs keep tracking sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= dec;
        end
    end

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed bench for decoder_2to4: select sweep, reset, latency, mid-run reset and X-select.
module tb_decoder_2to4;

    logic       clk;
    logic       rst;
    logic       a0;
    logic       a1;
    logic       d0, d1, d2, d3;
    logic [3:0] q;

    int errors = 0;
    int checks = 0;
    bit done   = 0;
    bit four_state;

    decoder_2to4 dut (
        .clk (clk),
        .rst (rst),
        .a0  (a0),
        .a1  (a1),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!done) begin
            check1("q_onehot0", $onehot0(q), 1'b1);
            if (!$isunknown({a1, a0}))
                check1("d_onehot", $onehot({d3, d2, d1, d0}), 1'b1);
        end
    end

    initial begin
        $monitor("%0t a0=%b a1=%b d3..d0=%b%b%b%b", $time, a0, a1, d3, d2, d1, d0);
    end

    initial begin
        logic probe;
        logic [1:0] sweep_sel [4];
        logic [3:0] sweep_exp [4];
        sweep_sel = '{2'b00, 2'b01, 2'b10, 2'b11};
        sweep_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        probe      = 1'bx;
        four_state = (probe === 1'bx);

        rst = 1'b1;
        a0  = 1'b0;
        a1  = 1'b0;
        tick();
        tick();
        check4("reset_q", q, 4'b0000);
        check4("reset_d", {d3, d2, d1, d0}, 4'b0001);

        // Sweep while held in reset: d follows within 1 ns of each change.
        for (int i = 0; i < 4; i++) begin
            {a1, a0} = sweep_sel[i];
            #1;
            check4($sformatf("sweep_%0d", i), {d3, d2, d1, d0}, sweep_exp[i]);
            #4;
        end

        // Reset held two edges with select 10, then released.
        {a1, a0} = 2'b10;
        rst = 1'b1;
        tick();
        tick();
        check4("rst_hold_q", q, 4'b0000);
        check1("rst_hold_d2", d2, 1'b1);
        rst = 1'b0;
        tick();
        check4("rst_release_q", q, 4'b0100);

        // Latency: change between edges, q waits for the next edge.
        {a1, a0} = 2'b00;
        tick();
        check4("lat_q_before", q, 4'b0001);
        #2;
        {a1, a0} = 2'b11;
        #1;
        check1("lat_d3_now", d3, 1'b1);
        check4("lat_q_hold", q, 4'b0001);
        tick();
        check4("lat_q_after", q, 4'b1000);

        // Mid-run reset for one edge.
        {a1, a0} = 2'b01;
        tick();
        check4("mid_q_pre", q, 4'b0010);
        rst = 1'b1;
        tick();
        check4("mid_q_rst", q, 4'b0000);
        check1("mid_d1", d1, 1'b1);
        rst = 1'b0;
        tick();
        check4("mid_q_post", q, 4'b0010);

        // X on a select bit: decode falls to all-zero where X exists.
        a1 = 1'b0;
        a0 = 1'bx;
        #1;
        check1("x_d_known", !$isunknown({d3, d2, d1, d0}), 1'b1);
        check1("x_d_onehot0", $onehot0({d3, d2, d1, d0}), 1'b1);
        if (four_state) check4("x_d_zero", {d3, d2, d1, d0}, 4'b0000);
        tick();
        check1("x_q_known", !$isunknown(q), 1'b1);
        if (four_state) check4("x_q_zero", q, 4'b0000);

        // Back to a known select.
        {a1, a0} = 2'b11;
        tick();
        check4("final_q", q, 4'b1000);

        done = 1'b1;
        $monitoroff;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: observed no finish expected finish by 5000 ns");
        $fatal(1, "timeout");
    end

endmodule
